// File: rtl/bp_cache_dma_mem_responder.sv
// Memory-side responder for the bsg_cache DMA interface, backed by an internal word array.
// Define BP_DMA_MEM_STATS_EN to add saturating read/write block counters (rd_blocks_o, wr_blocks_o).
module bp_cache_dma_mem_responder #(
    parameter int addr_width_p  = 28,
    parameter int data_width_p  = 64,
    parameter int block_beats_p = 8,
    parameter int mem_els_p     = 4096,
    parameter int read_delay_p  = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [addr_width_p:0]   dma_pkt_i,
    input  logic                    dma_pkt_v_i,
    output logic                    dma_pkt_yumi_o,
    output logic [data_width_p-1:0] dma_data_o,
    output logic                    dma_data_v_o,
    input  logic                    dma_data_ready_and_i,
    input  logic [data_width_p-1:0] dma_data_i,
    input  logic                    dma_data_v_i,
    output logic                    dma_data_yumi_o
`ifdef BP_DMA_MEM_STATS_EN
    ,
    output logic [31:0]             rd_blocks_o,
    output logic [31:0]             wr_blocks_o
`endif
);

    localparam int offset_lp  = $clog2(data_width_p / 8);
    localparam int beat_w_lp  = (block_beats_p > 1) ? $clog2(block_beats_p) : 1;
    localparam int idx_w_lp   = $clog2(mem_els_p);
    localparam int delay_w_lp = (read_delay_p > 1) ? $clog2(read_delay_p) : 1;

    typedef logic [idx_w_lp-1:0]   idx_t;
    typedef logic [beat_w_lp-1:0]  beat_t;
    typedef logic [delay_w_lp-1:0] delay_t;
    typedef enum logic [1:0] {IDLE, DELAY, READ, WRITE} state_e;

    state_e state_r, state_n;
    beat_t  beat_cnt_r, beat_cnt_n;
    delay_t delay_cnt_r, delay_cnt_n;
    idx_t   base_r, base_n;
    idx_t   mem_idx;
    logic   beat_last;

    logic [data_width_p-1:0] mem [mem_els_p];

    // The base has its beat bits cleared, so OR-ing the beat count keeps the index inside the block.
    assign mem_idx   = base_r | idx_t'(beat_cnt_r);
    assign beat_last = (beat_cnt_r == beat_t'(block_beats_p - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_n         = state_r;
        beat_cnt_n      = beat_cnt_r;
        delay_cnt_n     = delay_cnt_r;
        base_n          = base_r;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_v_o    = 1'b0;
        dma_data_o      = '0;
        dma_data_yumi_o = 1'b0;
        unique case (state_r)
            IDLE: begin
                dma_pkt_yumi_o = dma_pkt_v_i & reset_n_i;
                if (dma_pkt_v_i) begin
                    base_n      = idx_t'(dma_pkt_i[addr_width_p-1:0] >> offset_lp)
                                  & ~idx_t'(block_beats_p - 1);
                    beat_cnt_n  = '0;
                    delay_cnt_n = '0;
                    if (dma_pkt_i[addr_width_p])
                        state_n = WRITE;
                    else
                        state_n = (read_delay_p == 0) ? READ : DELAY;
                end
            end
            DELAY: begin
                if (delay_cnt_r == delay_t'(read_delay_p - 1)) begin
                    delay_cnt_n = '0;
                    state_n     = READ;
                end else begin
                    delay_cnt_n = delay_cnt_r + 1'b1;
                end
            end
            READ: begin
                dma_data_v_o = 1'b1;
                dma_data_o   = mem[mem_idx];
                if (dma_data_ready_and_i) begin
                    beat_cnt_n = beat_last ? '0 : beat_cnt_r + 1'b1;
                    if (beat_last) state_n = IDLE;
                end
            end
            WRITE: begin
                dma_data_yumi_o = dma_data_v_i;
                if (dma_data_v_i) begin
                    beat_cnt_n = beat_last ? '0 : beat_cnt_r + 1'b1;
                    if (beat_last) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            beat_cnt_r  <= '0;
            delay_cnt_r <= '0;
            base_r      <= '0;
        end else begin
            state_r     <= state_n;
            beat_cnt_r  <= beat_cnt_n;
            delay_cnt_r <= delay_cnt_n;
            base_r      <= base_n;
        end
    end

    // NOTE: the backing array has no reset so its contents survive a reset and it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (dma_data_yumi_o)
            mem[mem_idx] <= dma_data_i;
    end

`ifdef BP_DMA_MEM_STATS_EN
    logic rd_done, wr_done;
    assign rd_done = dma_data_v_o & dma_data_ready_and_i & beat_last;
    assign wr_done = dma_data_yumi_o & beat_last;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_blocks_o <= '0;
            wr_blocks_o <= '0;
        end else begin
            if (rd_done && (rd_blocks_o != '1)) rd_blocks_o <= rd_blocks_o + 1'b1;
            if (wr_done && (wr_blocks_o != '1)) wr_blocks_o <= wr_blocks_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_cache_dma_mem_responder.sv
// Self-checking bench for bp_cache_dma_mem_responder: a default instance (4096 words, delay 4)
// and a small instance (16 words, delay 0) share stimulus through a select; BP_DMA_MEM_STATS_EN aware.
module tb_bp_cache_dma_mem_responder;

    localparam int AW = 28, DW = 64, BEATS = 8;
    localparam int ELS0 = 4096, DLY0 = 4, ELS1 = 16, DLY1 = 0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sel;
    logic [AW:0]   pkt;
    logic          pkt_v, ready, dv_in;
    logic [DW-1:0] d_in;

    logic          yumi0, yumi1, vout0, vout1, dyumi0, dyumi1;
    logic [DW-1:0] dout0, dout1;
    logic          obs_pkt_yumi, obs_v, obs_dyumi;
    logic [DW-1:0] obs_data;
`ifdef BP_DMA_MEM_STATS_EN
    logic [31:0]   rdb0, wrb0, rdb1, wrb1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt0  = 0;
    int wr_cnt0  = 0;

    logic [DW-1:0] mdl0 [int];
    logic [DW-1:0] mdl1 [int];
    logic [AW-1:0] written0 [$];
    logic [AW-1:0] written1 [$];

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;     // write: first beat; read: expected first beat
        bit            sel;
        int            exp_lat;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    bp_cache_dma_mem_responder #(
        .addr_width_p(AW), .data_width_p(DW), .block_beats_p(BEATS),
        .mem_els_p(ELS0), .read_delay_p(DLY0)
    ) dut0 (
        .clk_i(clk), .reset_n_i(reset_n),
        .dma_pkt_i(pkt), .dma_pkt_v_i(pkt_v & ~sel), .dma_pkt_yumi_o(yumi0),
        .dma_data_o(dout0), .dma_data_v_o(vout0), .dma_data_ready_and_i(ready & ~sel),
        .dma_data_i(d_in), .dma_data_v_i(dv_in & ~sel), .dma_data_yumi_o(dyumi0)
`ifdef BP_DMA_MEM_STATS_EN
        , .rd_blocks_o(rdb0), .wr_blocks_o(wrb0)
`endif
    );

    bp_cache_dma_mem_responder #(
        .addr_width_p(AW), .data_width_p(DW), .block_beats_p(BEATS),
        .mem_els_p(ELS1), .read_delay_p(DLY1)
    ) dut1 (
        .clk_i(clk), .reset_n_i(reset_n),
        .dma_pkt_i(pkt), .dma_pkt_v_i(pkt_v & sel), .dma_pkt_yumi_o(yumi1),
        .dma_data_o(dout1), .dma_data_v_o(vout1), .dma_data_ready_and_i(ready & sel),
        .dma_data_i(d_in), .dma_data_v_i(dv_in & sel), .dma_data_yumi_o(dyumi1)
`ifdef BP_DMA_MEM_STATS_EN
        , .rd_blocks_o(rdb1), .wr_blocks_o(wrb1)
`endif
    );

    assign obs_pkt_yumi = sel ? yumi1  : yumi0;
    assign obs_v        = sel ? vout1  : vout0;
    assign obs_dyumi    = sel ? dyumi1 : dyumi0;
    assign obs_data     = sel ? dout1  : dout0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // First word index of the block holding byte address a, in a store of els words.
    function automatic int blk(input logic [AW-1:0] a, input int els);
        int word;
        word = int'(a) / (DW / 8);
        return ((word / BEATS) * BEATS) % els;
    endfunction

    function automatic logic [DW-1:0] model_rd(input int idx);
        if (sel) return mdl1.exists(idx) ? mdl1[idx] : 'x;
        return mdl0.exists(idx) ? mdl0[idx] : 'x;
    endfunction

    function automatic logic sig_of(input int which);
        case (which)
            0:       return obs_pkt_yumi;
            1:       return obs_v;
            default: return obs_dyumi;
        endcase
    endfunction

    // Bounded wait, sampling at negedges; returns with time at a negedge.
    task automatic wait_for(input int which, input string name, output int cycles);
        int n = 0;
        @(negedge clk);
        while (!sig_of(which) && n < 64) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check(name, DW'(sig_of(which)), DW'(1));
        cycles = n;
    endtask

    task automatic send_pkt(input bit wr, input logic [AW-1:0] a);
        int n;
        pkt   = {wr, a};
        pkt_v = 1'b1;
        wait_for(0, "pkt_accept", n);
        @(posedge clk);
        #1;
        pkt_v = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] base_d);
        int n, idx;
        idx = blk(a, sel ? ELS1 : ELS0);
        send_pkt(1'b1, a);
        for (int i = 0; i < BEATS; i++) begin
            d_in  = base_d + DW'(i);
            dv_in = 1'b1;
            wait_for(2, "wr_beat_yumi", n);
            @(posedge clk);
            #1;
            if (sel) mdl1[idx + i] = base_d + DW'(i);
            else     mdl0[idx + i] = base_d + DW'(i);
        end
        dv_in = 1'b0;
        if (sel) written1.push_back(a);
        else begin
            written0.push_back(a);
            wr_cnt0++;
        end
    endtask

    // Reads one block; expected beats come from the table (use_tab) or from the model.
    task automatic do_read(input logic [AW-1:0] a, input int exp_lat, input int stall_beat,
                           input int stall_cyc, input bit use_tab, input logic [DW-1:0] tab_base);
        int n, idx;
        logic [DW-1:0] exp;
        idx = blk(a, sel ? ELS1 : ELS0);
        ready = 1'b1;
        send_pkt(1'b0, a);
        for (int i = 0; i < BEATS; i++) begin
            exp = use_tab ? tab_base + DW'(i) : model_rd(idx + i);
            if (i == stall_beat && stall_cyc > 0) begin
                ready = 1'b0;
                pkt   = {1'b1, AW'(0)};
                pkt_v = 1'b1;
                for (int k = 0; k < stall_cyc; k++) begin
                    @(negedge clk);
                    check("stall_valid", DW'(obs_v), DW'(1));
                    check("stall_data", obs_data, exp);
                    check("busy_pkt_yumi", DW'(obs_pkt_yumi), DW'(0));
                    @(posedge clk);
                    #1;
                end
                pkt_v = 1'b0;
                ready = 1'b1;
            end
            wait_for(1, "rd_beat_valid", n);
            if (i == 0) check("rd_latency", DW'(n + 1), DW'(exp_lat));
            check("rd_beat_data", obs_data, exp);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("rd_end_valid", DW'(obs_v), DW'(0));
        @(posedge clk);
        #1;
        if (!sel) rd_cnt0++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [AW-1:0] a, pick;
        logic [DW-1:0] d;

        vecs[0] = '{1'b1, 28'h40, 64'h1000, 1'b0, 0};
        vecs[1] = '{1'b0, 28'h40, 64'h1000, 1'b0, DLY0 + 1};
        vecs[2] = '{1'b0, 28'h4C, 64'h1000, 1'b0, DLY0 + 1};
        vecs[3] = '{1'b1, 28'h80, 64'hA000, 1'b1, 0};
        vecs[4] = '{1'b0, 28'h0,  64'hA000, 1'b1, DLY1 + 1};
        vecs[5] = '{1'b0, 28'h8C, 64'hA000, 1'b1, DLY1 + 1};

        sel = 1'b0; pkt = '0; pkt_v = 1'b1; ready = 1'b1; dv_in = 1'b1; d_in = '0;
        reset_n = 1'b0;
        #12;
        check("rst_pkt_yumi0", DW'(yumi0), DW'(0));
        check("rst_pkt_yumi1", DW'(yumi1), DW'(0));
        check("rst_data_v0", DW'(vout0), DW'(0));
        check("rst_data_v1", DW'(vout1), DW'(0));
        check("rst_data_yumi0", DW'(dyumi0), DW'(0));
        check("rst_data_yumi1", DW'(dyumi1), DW'(0));
`ifdef BP_DMA_MEM_STATS_EN
        check("rst_rd_blocks", DW'(rdb0), DW'(0));
        check("rst_wr_blocks", DW'(wrb0), DW'(0));
`endif
        pkt_v = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Stray write beats while idle must not be consumed.
        for (int s = 0; s < 2; s++) begin
            sel   = s[0];
            dv_in = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("idle_stray_yumi", DW'(obs_dyumi), DW'(0));
                @(posedge clk);
                #1;
            end
            dv_in = 1'b0;
        end

        for (int k = 0; k < 6; k++) begin
            sel = vecs[k].sel;
            if (vecs[k].wr) do_write(vecs[k].addr, vecs[k].data);
            else do_read(vecs[k].addr, vecs[k].exp_lat, -1, 0, 1'b1, vecs[k].data);
`ifdef BP_DMA_MEM_STATS_EN
            if (k == 1) begin
                check("stats_rd_after_t1", DW'(rdb0), DW'(1));
                check("stats_wr_after_t1", DW'(wrb0), DW'(1));
            end
`endif
        end

        // Backpressure: beat 2 held for three cycles.
        sel = 1'b0;
        do_read(28'h40, DLY0 + 1, 2, 3, 1'b1, 64'h1000);

        // Reset in the middle of a read, after beat 3 has retired.
        ready = 1'b1;
        send_pkt(1'b0, 28'h40);
        for (int i = 0; i < 4; i++) begin
            wait_for(1, "pre_reset_valid", n);
            check("pre_reset_data", obs_data, 64'h1000 + DW'(i));
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", DW'(vout0), DW'(0));
        check("async_rst_data", dout0, DW'(0));
        check("async_rst_pkt_yumi", DW'(yumi0), DW'(0));
        rd_cnt0 = 0;
        wr_cnt0 = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_read(28'h40, DLY0 + 1, -1, 0, 1'b1, 64'h1000);
        sel = 1'b1;
        do_read(28'h0, DLY1 + 1, -1, 0, 1'b1, 64'hA000);

        // Random writes followed by unaligned reads of previously written blocks.
        for (int r = 0; r < 16; r++) begin
            sel = r[0];
            a   = AW'($urandom);
            d   = {$urandom, $urandom};
            do_write(a, d);
            if (sel) pick = written1[$urandom_range(0, written1.size() - 1)];
            else     pick = written0[$urandom_range(0, written0.size() - 1)];
            pick[5:0] = 6'($urandom);
            do_read(pick, sel ? DLY1 + 1 : DLY0 + 1, $urandom_range(1, BEATS - 1),
                    $urandom_range(0, 2), 1'b0, '0);
        end

`ifdef BP_DMA_MEM_STATS_EN
        check("stats_rd_final", DW'(rdb0), DW'(rd_cnt0));
        check("stats_wr_final", DW'(wrb0), DW'(wr_cnt0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
